// File: rtl/code_pulse_decoder_pkg.sv
// Shared definitions for the code pulse decoder: FSM encoding, code and line widths.
package code_pulse_decoder_pkg;

  localparam int CODE_W = 2;
  localparam int LINES  = 4;
  localparam int HOLD_W = 4;
  localparam int PCNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_e;

  // One-hot line pattern for a binary line index.
  function automatic logic [LINES-1:0] one_hot(input logic [CODE_W-1:0] code);
    return LINES'(1) << code;
  endfunction

endpackage

// File: rtl/code_fifo.sv
// Small synchronous FIFO for queued codes; pointers wrap modulo DEPTH (power of two).
module code_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next pointer and occupancy; a simultaneous push and pop keeps the count.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; entries are only read when the count says they are valid.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointers alone define validity.
    if (push_ok) mem[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/code_pulse_decoder.sv
// Queues 2-bit codes and plays each out as a PULSE_LEN-cycle one-hot pulse followed by a gap.
module code_pulse_decoder
  import code_pulse_decoder_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PULSE_LEN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_code,
  output logic              in_ready,
  output logic [LINES-1:0]  d_out,
  output logic              busy,
  output logic [PCNT_W-1:0] pulse_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [LINES-1:0]    d_out_q, d_out_d;
  logic [PCNT_W-1:0]   pulse_q, pulse_d;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CODE_W-1:0]   fifo_dout;
  logic [CW-1:0]       fifo_count;

  // Ready reflects free space only; a pop in the same cycle never frees a slot early.
  assign in_ready  = !rst_n || (fifo_count < CW'(DEPTH));
  assign fifo_push = rst_n && in_valid && !fifo_full;
  assign busy      = rst_n && (!fifo_empty || (state_q != IDLE));
  assign d_out     = d_out_q;
  assign pulse_cnt = pulse_q;

  code_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CODE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (in_code),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Next-state logic: pop into DRIVE, count down the hold, then one GAP cycle.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    code_d   = code_q;
    pulse_d  = pulse_q;
    fifo_pop = 1'b0;
    // d_out follows the registered state, which yields the two-cycle push-to-line latency.
    d_out_d  = (state_q == DRIVE) ? one_hot(code_q) : '0;
    case (state_q)
      IDLE, GAP: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          code_d   = fifo_dout;
          hold_d   = HOLD_W'(PULSE_LEN - 1);
          state_d  = DRIVE;
        end else begin
          state_d  = IDLE;
        end
      end
      DRIVE: begin
        if (hold_q == '0) begin
          state_d = GAP;
          pulse_d = pulse_q + PCNT_W'(1);
        end else begin
          hold_d  = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, hold counter, line and pulse-count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      code_q  <= '0;
      d_out_q <= '0;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      code_q  <= code_d;
      d_out_q <= d_out_d;
      pulse_q <= pulse_d;
    end
  end

endmodule

// File: tb/tb_code_pulse_decoder.sv
// Self-checking bench: two decoders (PULSE_LEN 2 and 1) share stimulus; a queue-based
// timeline model predicts every output each cycle, plus literal directed expectations.
module tb_code_pulse_decoder;

  localparam int DEPTH = 4;
  localparam int LEN0  = 2;
  localparam int LEN1  = 1;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_code;
  logic       rdy0, rdy1, busy0, busy1;
  logic [3:0] dout0, dout1;
  logic [7:0] pc0, pc1;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: per instance, a FIFO of codes plus the edge index of the latest pop.
  int t = 0;
  int mbuf   [2][256];
  int mhead  [2];
  int mtail  [2];
  int mp     [2];
  int mhave  [2];
  int mcode  [2];
  int mpulse [2];
  int mnext  [2];

  logic [3:0] prev_d0 = '0;
  logic [7:0] prev_pc0 = '0;
  int         saw_wrap = 0;
  int         saw_low  = 0;
  int         em_q[$];

  code_pulse_decoder #(.DEPTH(DEPTH), .PULSE_LEN(LEN0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
    .in_ready(rdy0), .d_out(dout0), .busy(busy0), .pulse_cnt(pc0)
  );

  code_pulse_decoder #(.DEPTH(DEPTH), .PULSE_LEN(LEN1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
    .in_ready(rdy1), .d_out(dout1), .busy(busy1), .pulse_cnt(pc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0h expected %0h", name, t, got, exp);
    end
  endtask

  function automatic int plen(input int k);
    return (k == 0) ? LEN0 : LEN1;
  endfunction

  function automatic int msize(input int k);
    return mtail[k] - mhead[k];
  endfunction

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_edge();
    t++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mhead[k] = 0; mtail[k] = 0; mhave[k] = 0; mpulse[k] = 0; mnext[k] = 0;
      end else begin
        int  pre;
        bit  push;
        pre  = msize(k);
        push = in_valid && (pre < DEPTH);
        if (pre > 0 && t >= mnext[k]) begin
          mcode[k] = mbuf[k][mhead[k] % 256];
          mhead[k]++;
          mp[k]    = t;
          mhave[k] = 1;
          mnext[k] = t + plen(k) + 1;
        end
        if (mhave[k] != 0 && t == mp[k] + plen(k)) mpulse[k] = (mpulse[k] + 1) % 256;
        if (push) begin
          mbuf[k][mtail[k] % 256] = int'(in_code);
          mtail[k]++;
        end
      end
    end
  endtask

  // Compare every output of both instances against the model.
  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      logic [3:0] ed;
      logic       eb, er;
      ed = (mhave[k] != 0 && t >= mp[k] + 1 && t <= mp[k] + plen(k)) ? (4'b0001 << mcode[k]) : 4'b0000;
      eb = rst_n && (msize(k) > 0 || (mhave[k] != 0 && t <= mp[k] + plen(k)));
      er = !rst_n || (msize(k) < DEPTH);
      check($sformatf("d_out%0d", k),     (k == 0) ? 32'(dout0) : 32'(dout1), 32'(ed));
      check($sformatf("busy%0d", k),      (k == 0) ? 32'(busy0) : 32'(busy1), 32'(eb));
      check($sformatf("in_ready%0d", k),  (k == 0) ? 32'(rdy0)  : 32'(rdy1),  32'(er));
      check($sformatf("pulse_cnt%0d", k), (k == 0) ? 32'(pc0)   : 32'(pc1),   32'(mpulse[k]));
    end
    if (prev_pc0 == 8'd255 && pc0 == 8'd0) saw_wrap = 1;
    prev_pc0 = pc0;
    if (!rdy0) saw_low = 1;
    if (dout0 != 4'b0000 && prev_d0 == 4'b0000) begin
      case (dout0)
        4'b0001: em_q.push_back(0);
        4'b0010: em_q.push_back(1);
        4'b0100: em_q.push_back(2);
        default: em_q.push_back(3);
      endcase
    end
    prev_d0 = dout0;
  endtask

  // One cycle: drive inputs after the falling edge, compare, then cross the rising edge.
  task automatic step(input logic v, input logic [1:0] c, input logic r);
    @(negedge clk);
    in_valid = v;
    in_code  = c;
    rst_n    = r;
    #1;
    compare_all();
    @(posedge clk);
    model_edge();
  endtask

  task automatic do_reset();
    step(1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    logic [3:0] exp36 [9];
    int         seq37 [6];
    exp36 = '{4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
    seq37 = '{1, 3, 2, 0, 2, 1};
    for (int k = 0; k < 2; k++) begin
      mhead[k] = 0; mtail[k] = 0; mhave[k] = 0; mpulse[k] = 0; mnext[k] = 0; mp[k] = 0; mcode[k] = 0;
    end
    rst_n = 1'b0; in_valid = 1'b0; in_code = 2'd0;

    // Reset state and single code 2.
    do_reset();
    #1;
    check("rst_d_out", 32'(dout0), 32'h0);
    check("rst_pulse_cnt", 32'(pc0), 32'h0);
    check("rst_busy", 32'(busy0), 32'h0);
    check("rst_in_ready", 32'(rdy0), 32'h1);
    step(1'b1, 2'd2, 1'b1); #1; check("single_n0", 32'(dout0), 32'h0);
    step(1'b0, 2'd0, 1'b1); #1; check("single_n1", 32'(dout0), 32'h0);
    step(1'b0, 2'd0, 1'b1); #1; check("single_n2", 32'(dout0), 32'h4);
    step(1'b0, 2'd0, 1'b1); #1; check("single_n3", 32'(dout0), 32'h4);
    step(1'b0, 2'd0, 1'b1); #1; check("single_n4", 32'(dout0), 32'h0);
    check("single_pulse_cnt", 32'(pc0), 32'h1);
    check("single_busy_after", 32'(busy0), 32'h0);

    // Back-to-back 3,0,1.
    do_reset();
    step(1'b1, 2'd3, 1'b1);
    step(1'b1, 2'd0, 1'b1);
    step(1'b1, 2'd1, 1'b1);
    #1; check("b2b_0", 32'(dout0), 32'(exp36[0]));
    for (int i = 1; i < 9; i++) begin
      step(1'b0, 2'd0, 1'b1);
      #1; check($sformatf("b2b_%0d", i), 32'(dout0), 32'(exp36[i]));
    end
    check("b2b_pulse_cnt", 32'(pc0), 32'h3);

    // Six codes with in_valid held; the upstream keeps a code until accepted.
    do_reset();
    saw_low = 0;
    em_q.delete();
    begin
      int sent;
      sent = 0;
      for (int c = 0; c < 40; c++) begin
        bit acc;
        acc = (sent < 6) && (msize(0) < DEPTH);
        step(sent < 6, (sent < 6) ? 2'(seq37[sent]) : 2'd0, 1'b1);
        if (acc) sent++;
      end
      check("full_all_sent", 32'(sent), 32'd6);
    end
    check("full_ready_dropped", 32'(saw_low), 32'd1);
    check("full_emit_count", 32'(em_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < em_q.size(); i++)
      check($sformatf("full_order_%0d", i), 32'(em_q[i]), 32'(seq37[i]));

    // Reset in the second cycle of a pulse with three codes queued.
    do_reset();
    step(1'b1, 2'd0, 1'b1);
    step(1'b1, 2'd1, 1'b1);
    step(1'b1, 2'd2, 1'b1);
    step(1'b1, 2'd3, 1'b1);
    #1; check("midrst_pulse_on", 32'(dout0), 32'h1);
    step(1'b1, 2'd1, 1'b0);
    #1;
    check("midrst_d_out", 32'(dout0), 32'h0);
    check("midrst_pulse_cnt", 32'(pc0), 32'h0);
    check("midrst_in_ready", 32'(rdy0), 32'h1);
    check("midrst_busy", 32'(busy0), 32'h0);
    step(1'b0, 2'd0, 1'b1);
    #1;
    check("midrst_empty_d_out", 32'(dout0), 32'h0);
    check("midrst_empty_busy", 32'(busy0), 32'h0);

    // PULSE_LEN=1 instance with codes 0,0.
    do_reset();
    step(1'b1, 2'd0, 1'b1);
    step(1'b1, 2'd0, 1'b1); #1; check("len1_n1", 32'(dout1), 32'h0);
    step(1'b0, 2'd0, 1'b1); #1; check("len1_n2", 32'(dout1), 32'h1);
    step(1'b0, 2'd0, 1'b1); #1; check("len1_n3", 32'(dout1), 32'h0);
    step(1'b0, 2'd0, 1'b1); #1; check("len1_n4", 32'(dout1), 32'h1);
    step(1'b0, 2'd0, 1'b1); #1; check("len1_n5", 32'(dout1), 32'h0);
    check("len1_pulse_cnt", 32'(pc1), 32'h2);

    // Saturated stream long enough for pulse_cnt and pointers to wrap.
    do_reset();
    saw_wrap = 0;
    for (int c = 0; c < 1100; c++) step(1'b1, 2'($urandom_range(0, 3)), 1'b1);
    check("pulse_cnt_wrap", 32'(saw_wrap), 32'd1);

    // Random traffic with occasional resets.
    for (int c = 0; c < 2500; c++)
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ($urandom_range(0, 399) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
